// File: rtl/icache_responder.sv
// Direct-mapped, read-only instruction cache responder for the fetch stage.
// Hits are answered combinationally; a miss runs one tagged load to backing
// memory and the fill data is forwarded to fetch in the cycle it arrives.
module icache_responder #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned SETS = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [XLEN-1:0] proc2Icache_addr,
    output logic [63:0]     Icache2proc_data,
    output logic            Icache2proc_valid,
    input  logic            Imem_grant,
    output logic [1:0]      proc2Imem_command,
    output logic [XLEN-1:0] proc2Imem_addr,
    input  logic [3:0]      Imem2proc_response,
    input  logic [63:0]     Imem2proc_data,
    input  logic [3:0]      Imem2proc_tag
);

    localparam int unsigned IDX  = $clog2(SETS);
    localparam int unsigned TAGW = XLEN - 3 - IDX;

    localparam logic [1:0] CmdNone = 2'd0;
    localparam logic [1:0] CmdLoad = 2'd1;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait
    } state_e;

    state_e          state_q;
    logic [XLEN-1:0] miss_addr_q;
    logic [3:0]      saved_tag_q;

    logic [SETS-1:0] line_valid_q;
    logic [TAGW-1:0] line_tag_q  [SETS];
    logic [63:0]     line_data_q [SETS];

    logic [IDX-1:0]  req_idx;
    logic [TAGW-1:0] req_tag;
    logic [IDX-1:0]  miss_idx;
    logic [TAGW-1:0] miss_tag;
    logic            hit;
    logic            same_line;
    logic            granted;
    logic            accepted;
    logic            fill;
    logic            fwd;

    // Offset bits within the 8-byte line never affect the lookup.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^proc2Icache_addr[2:0];

    // Address decode and handshake qualifiers.
    always_comb begin
        req_idx   = proc2Icache_addr[3 +: IDX];
        req_tag   = proc2Icache_addr[XLEN-1 -: TAGW];
        miss_idx  = miss_addr_q[3 +: IDX];
        miss_tag  = miss_addr_q[XLEN-1 -: TAGW];
        hit       = line_valid_q[req_idx] && (line_tag_q[req_idx] == req_tag);
        same_line = (proc2Icache_addr[XLEN-1:3] == miss_addr_q[XLEN-1:3]);
        granted   = (state_q == StReq) && Imem_grant;
        accepted  = granted && (Imem2proc_response != 4'd0);
        // A zero saved tag means nothing is outstanding, so tag 0 never matches.
        fill      = (state_q == StWait) && (saved_tag_q != 4'd0)
                    && (Imem2proc_tag == saved_tag_q);
        fwd       = fill && same_line;
    end

    // Fetch-side and memory-side outputs; fill forwarding wins over stale array data.
    always_comb begin
        Icache2proc_valid = 1'b0;
        Icache2proc_data  = 64'd0;
        if (fwd) begin
            Icache2proc_valid = 1'b1;
            Icache2proc_data  = Imem2proc_data;
        end else if (hit) begin
            Icache2proc_valid = 1'b1;
            Icache2proc_data  = line_data_q[req_idx];
        end
        proc2Imem_command = granted ? CmdLoad : CmdNone;
        proc2Imem_addr    = granted ? miss_addr_q : '0;
    end

    // Miss-handling FSM plus per-line valid bits.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            miss_addr_q  <= '0;
            saved_tag_q  <= 4'd0;
            line_valid_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (!hit) begin
                        miss_addr_q <= {proc2Icache_addr[XLEN-1:3], 3'b000};
                        state_q     <= StReq;
                    end
                end
                StReq: begin
                    if (accepted) begin
                        saved_tag_q <= Imem2proc_response;
                        state_q     <= StWait;
                    end else if (!same_line) begin
                        // Fetch redirected before memory took the request: drop it.
                        state_q <= StIdle;
                    end
                end
                StWait: begin
                    // Redirects are ignored here; the tagged fill must land.
                    if (fill) begin
                        line_valid_q[miss_idx] <= 1'b1;
                        saved_tag_q            <= 4'd0;
                        state_q                <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Line storage; only the valid bits need reset.
    always_ff @(posedge clock) begin
        if (!reset && fill) begin
            line_tag_q[miss_idx]  <= miss_tag;
            line_data_q[miss_idx] <= Imem2proc_data;
        end
    end

endmodule
